div_sched: RTL and testbench
============================

# div_sched

Round-robin scheduler that shares the single free-running 16-bit long-division unit among NREQ requesters, such as register-file math ops and blitter address math. It arbitrates requests and latches the winner's operands. It aligns the operands to the divider's load window, waits out the 16 iterations, and returns quotient, remainder and requester ID on a shared response bus. It sits between the requesting blocks and the divide unit; the divider's ports connect directly to the `div_*` ports.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of resp_id; must equal clog2(NREQ)
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  request pending per requester
- req_sign  in  NREQ  1 = signed two's-complement divide
- req_dividend  in  16*NREQ  requester i occupies bits [16i+15:16i]
- req_divisor  in  16*NREQ  same packing
- req_ready  out  NREQ  one-hot grant; combinational, high in the grant cycle
- resp_valid  out  1  one-cycle result pulse
- resp_id  out  IDW  index of the requester that owns the result
- resp_quotient  out  16  quotient
- resp_remainder  out  16  remainder
- resp_dz  out  1  divisor was zero
- busy  out  1  high in ARM and RUN
- div_sign / div_dividend / div_divisor  out  1/16/16  operands to the divider; registered
- div_done  in  1  divider idle/load cycle
- div_quotient / div_remainder  in  16/16  divider results; valid only while div_done=1

## Operation
- Divider behaviour:
  - It reloads its operands on every edge where div_done=1.
  - div_done is high for exactly one cycle in every 17.
  - Its results are valid only in that cycle and are cleared at the following edge.
  - It has no reset.
- States: IDLE, ARM, RUN.
- IDLE:
  - If any req_valid is high, the winner is the first set bit searched upward from rr_ptr, wrapping.
  - req_ready[winner] is high in that cycle.
  - At the edge, the winner's sign, dividend and divisor are latched into div_*, resp_id is captured, and rr_ptr becomes (winner+1) mod NREQ.
  - Next state is ARM.
- ARM:
  - Hold div_*.
  - When div_done=1, the divider loads the operands at that edge; go to RUN.
- RUN:
  - Wait for div_done=1. At that edge, capture div_quotient into resp_quotient and div_remainder into resp_remainder.
  - Set resp_dz = (latched divisor == 0). resp_valid is high for the next cycle. Return to IDLE.
  - div_done is low on entry to RUN, so the ARM load cycle is never mistaken for completion.
- Handshake:
  - A requester holds req_valid and its operands stable until it sees req_ready.
  - Dropping req_valid before a grant is legal and withdraws the request.
  - At most one request is outstanding at a time.
- Response bus: resp_quotient, resp_remainder, resp_id and resp_dz hold their values until the next response.
- Signed results follow divider semantics: quotient truncates toward zero, and the remainder sign is negated exactly when the quotient is negative.
- Reset values:
  - state IDLE, rr_ptr 0.
  - req_ready 0, resp_valid 0, resp_* 0, busy 0, div_* 0.
- Reset mid-operation: the operation is abandoned and no response is issued. The divider keeps running, and the next ARM re-synchronises on div_done.

## Timing
- Grant cycle g: req_ready is high.
- The first ARM cycle is g+1.
- ARM lasts 1–17 cycles, depending on the divider phase.
- resp_valid is high in cycle g+19 (best case) through g+35 (worst case).
- No new grant is issued while busy. The earliest next grant is the resp_valid cycle itself, so a grant and a response can coincide.
- Throughput is one divide per 34 cycles worst case.

## Configuration
- DIV_ZERO_BYPASS_EN defined:
  - In IDLE, a winner with divisor==0 does not use the divider; div_* are unchanged and the FSM stays in IDLE.
  - resp_valid is high in cycle g+1 with resp_quotient=0xFFFF, resp_remainder=raw dividend, resp_dz=1.
- DIV_ZERO_BYPASS_EN undefined:
  - A zero divisor goes through the divider like any other request.
  - The result is the divider's native output (unsigned: 0xFFFF, dividend); resp_dz=1.

## Test plan
- Unsigned divide: req0 requests 1000/7 -> resp_id=0, quotient=142, remainder=6, resp_valid 19–35 cycles after the grant.
- Signed divide: req1 requests -100/7 (0xFF9C/0x0007, sign=1) -> quotient=0xFFF2, remainder=0xFFFE.
- Round-robin order: all four requesters valid from reset -> grants in order 0,1,2,3. Then with only req0 and req2 valid -> grants 0 then 2. Each response carries the matching ID and correct result.
- Divide by zero: req3 requests 0x1234/0 unsigned.
  - With the macro: resp at g+1, quotient=0xFFFF, remainder=0x1234, dz=1, div_* untouched.
  - Without the macro: same values after the full latency.
- Reset mid-operation: rst pulsed during RUN -> next cycle all outputs are 0 and state is IDLE, with no resp_valid for the lost op. A following 500/3 request yields quotient=166, remainder=2.
- Phase sweep: start 50000/123 at each of the 17 div_done phases -> always quotient=406, remainder=62, latency within 19–35.

Source files
------------

// File: rtl/div_sched.sv
// -----------------------------------------------------------------------------
// div_sched -- round-robin scheduler sharing one free-running 16-bit
// long-division unit among NREQ requesters.
//
// A request is granted in IDLE, and its operands are latched onto div_*. The
// scheduler then waits in ARM for the divider's load cycle (div_done). In RUN
// it waits for the next div_done, when the result is captured onto the
// response bus and resp_valid pulses for one cycle.
//
// Optional feature (compile-time macro DIV_ZERO_BYPASS_EN):
//   When defined, a granted request with divisor == 0 is answered directly
//   from IDLE one cycle after the grant (quotient 0xFFFF, remainder = dividend,
//   resp_dz = 1) without touching the divider.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid[NREQ]        per-requester request pending
//   req_sign[NREQ]         1 = signed two's-complement divide
//   req_dividend/divisor   16 bits per requester, requester i at [16i+15:16i]
//   req_ready[NREQ]        one-hot grant, combinational, high in grant cycle
//   resp_valid             one-cycle result pulse
//   resp_id                requester owning the result
//   resp_quotient/remainder/resp_dz   result, held until the next response
//   busy                   high while in ARM or RUN
//   div_sign/dividend/divisor         registered operands to the divider
//   div_done               divider load/result cycle (1 in every 17)
//   div_quotient/remainder divider results, valid only while div_done = 1
// -----------------------------------------------------------------------------
module div_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_sign,
  input  logic [16*NREQ-1:0]   req_dividend,
  input  logic [16*NREQ-1:0]   req_divisor,
  output logic [NREQ-1:0]      req_ready,
  output logic                 resp_valid,
  output logic [IDW-1:0]       resp_id,
  output logic [15:0]          resp_quotient,
  output logic [15:0]          resp_remainder,
  output logic                 resp_dz,
  output logic                 busy,
  output logic                 div_sign,
  output logic [15:0]          div_dividend,
  output logic [15:0]          div_divisor,
  input  logic                 div_done,
  input  logic [15:0]          div_quotient,
  input  logic [15:0]          div_remainder
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic             div_sign_q, div_sign_d;
  logic [15:0]      div_dividend_q, div_dividend_d;
  logic [15:0]      div_divisor_q, div_divisor_d;
  logic             resp_valid_q, resp_valid_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [15:0]      resp_quotient_q, resp_quotient_d;
  logic [15:0]      resp_remainder_q, resp_remainder_d;
  logic             resp_dz_q, resp_dz_d;

  logic [IDW-1:0]   win;
  logic             sel_sign;
  logic [15:0]      sel_dividend;
  logic [15:0]      sel_divisor;

  // First set bit at or above ptr; if none, first set bit from 0 (wrap).
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [IDW-1:0]  ptr);
    logic [IDW-1:0] w;
    logic           found;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && v[i] && (IDW'(i) >= ptr)) begin
        w     = IDW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && v[i]) begin
        w     = IDW'(i);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] w);
    logic [IDW-1:0] n;
    if (w == IDW'(NREQ - 1)) n = '0;
    else                     n = w + 1'b1;
    return n;
  endfunction

  always_comb begin
    state_d          = state_q;
    rr_d             = rr_q;
    owner_d          = owner_q;
    div_sign_d       = div_sign_q;
    div_dividend_d   = div_dividend_q;
    div_divisor_d    = div_divisor_q;
    resp_valid_d     = 1'b0;
    resp_id_d        = resp_id_q;
    resp_quotient_d  = resp_quotient_q;
    resp_remainder_d = resp_remainder_q;
    resp_dz_d        = resp_dz_q;
    req_ready        = '0;

    win          = rr_pick(req_valid, rr_q);
    sel_sign     = 1'b0;
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win) begin
        sel_sign     = req_sign[i];
        sel_dividend = req_dividend[16*i +: 16];
        sel_divisor  = req_divisor[16*i +: 16];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (IDW'(i) == win);
          end
          rr_d    = rr_next(win);
          owner_d = win;
`ifdef DIV_ZERO_BYPASS_EN
          if (sel_divisor == 16'd0) begin
            // Answered locally; the divider operands are left untouched.
            resp_valid_d     = 1'b1;
            resp_id_d        = win;
            resp_quotient_d  = 16'hFFFF;
            resp_remainder_d = sel_dividend;
            resp_dz_d        = 1'b1;
          end else begin
            div_sign_d     = sel_sign;
            div_dividend_d = sel_dividend;
            div_divisor_d  = sel_divisor;
            state_d        = S_ARM;
          end
`else
          div_sign_d     = sel_sign;
          div_dividend_d = sel_dividend;
          div_divisor_d  = sel_divisor;
          state_d        = S_ARM;
`endif
        end
      end
      S_ARM: begin
        // The divider samples div_* on this edge; completion is 17 cycles on.
        if (div_done) state_d = S_RUN;
      end
      S_RUN: begin
        if (div_done) begin
          resp_valid_d     = 1'b1;
          resp_id_d        = owner_q;
          resp_quotient_d  = div_quotient;
          resp_remainder_d = div_remainder;
          resp_dz_d        = (div_divisor_q == 16'd0);
          state_d          = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rst) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      rr_q             <= '0;
      owner_q          <= '0;
      div_sign_q       <= 1'b0;
      div_dividend_q   <= '0;
      div_divisor_q    <= '0;
      resp_valid_q     <= 1'b0;
      resp_id_q        <= '0;
      resp_quotient_q  <= '0;
      resp_remainder_q <= '0;
      resp_dz_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      rr_q             <= rr_d;
      owner_q          <= owner_d;
      div_sign_q       <= div_sign_d;
      div_dividend_q   <= div_dividend_d;
      div_divisor_q    <= div_divisor_d;
      resp_valid_q     <= resp_valid_d;
      resp_id_q        <= resp_id_d;
      resp_quotient_q  <= resp_quotient_d;
      resp_remainder_q <= resp_remainder_d;
      resp_dz_q        <= resp_dz_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign div_sign       = div_sign_q;
  assign div_dividend   = div_dividend_q;
  assign div_divisor    = div_divisor_q;
  assign resp_valid     = resp_valid_q;
  assign resp_id        = resp_id_q;
  assign resp_quotient  = resp_quotient_q;
  assign resp_remainder = resp_remainder_q;
  assign resp_dz        = resp_dz_q;

endmodule

// File: tb/tb_div_sched.sv
// -----------------------------------------------------------------------------
// tb_div_sched -- testbench for div_sched with NREQ = 4. Provides a
// behavioural free-running divider (one load/result cycle in every 17) and
// checks grant order, latency, response fields and reset behaviour against
// a reference model of the scheduling and division rules.
// -----------------------------------------------------------------------------
module tb_div_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_sign, req_ready;
  logic [63:0] req_dividend, req_divisor;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [15:0] resp_quotient, resp_remainder;
  logic        resp_dz, busy, div_sign;
  logic [15:0] div_dividend, div_divisor;
  logic        div_done;
  logic [15:0] div_quotient, div_remainder;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int dcnt     = 7;
  int rr_exp   = 0;

  logic [15:0] opa [4];
  logic [15:0] opb [4];
  logic        ops [4];
  logic        last_s;
  logic [15:0] last_a, last_b;

  logic        ld_sign = 1'b0;
  logic [15:0] ld_a = 16'd0, ld_b = 16'd0;

  div_sched #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_sign(req_sign),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_quotient(resp_quotient), .resp_remainder(resp_remainder),
    .resp_dz(resp_dz), .busy(busy),
    .div_sign(div_sign), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider: magnitude divide, both results negated when operand signs differ.
  function automatic logic [31:0] native_div(input logic s, input logic [15:0] a,
                                             input logic [15:0] b);
    logic [16:0] ua, ub, uq, ur;
    logic        neg;
    if (b == 16'd0) return {16'hFFFF, a};
    if (s) begin
      ua  = a[15] ? (17'h10000 - {1'b0, a}) : {1'b0, a};
      ub  = b[15] ? (17'h10000 - {1'b0, b}) : {1'b0, b};
      neg = a[15] ^ b[15];
    end else begin
      ua  = {1'b0, a};
      ub  = {1'b0, b};
      neg = 1'b0;
    end
    uq = ua / ub;
    ur = ua % ub;
    if (neg) begin
      uq = -uq;
      ur = -ur;
    end
    return {uq[15:0], ur[15:0]};
  endfunction

  assign div_done = (dcnt == 0);
  always @(posedge clk) begin
    if (dcnt == 0) begin
      ld_sign <= div_sign;
      ld_a    <= div_dividend;
      ld_b    <= div_divisor;
    end
    dcnt <= (dcnt == 16) ? 0 : dcnt + 1;
  end
  always_comb begin
    div_quotient  = 16'd0;
    div_remainder = 16'd0;
    if (div_done) {div_quotient, div_remainder} = native_div(ld_sign, ld_a, ld_b);
  end

  // Expected result from the arithmetic rules: truncating signed quotient,
  // remainder magnitude carrying the quotient's sign.
  function automatic logic [31:0] exp_div(input logic s, input logic [15:0] a,
                                          input logic [15:0] b);
    int sa, sb, qi, m, ri;
    if (b == 16'd0) return {16'hFFFF, a};
    if (!s) return {a / b, a % b};
    sa = int'($signed(a));
    sb = int'($signed(b));
    qi = sa / sb;
    m  = (sa < 0 ? -sa : sa) % (sb < 0 ? -sb : sb);
    ri = (qi < 0) ? -m : m;
    return {qi[15:0], ri[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_bus();
    req_dividend = {opa[3], opa[2], opa[1], opa[0]};
    req_divisor  = {opb[3], opb[2], opb[1], opb[0]};
    req_sign     = {ops[3], ops[2], ops[1], ops[0]};
  endtask

  task automatic model_reset();
    rr_exp = 0;
    last_s = 1'b0;
    last_a = 16'd0;
    last_b = 16'd0;
  endtask

  task automatic zero_chk(input string p);
    chk({p, "_resp_valid"}, resp_valid, 0);
    chk({p, "_resp_id"}, resp_id, 0);
    chk({p, "_resp_q"}, resp_quotient, 0);
    chk({p, "_resp_r"}, resp_remainder, 0);
    chk({p, "_resp_dz"}, resp_dz, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_div_ops"}, {15'd0, div_sign, div_dividend, div_divisor} , 0);
    chk({p, "_req_ready"}, req_ready, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = 4'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    zero_chk("rst");
    rst = 1'b0;
    model_reset();
  endtask

  // Called at (or just after) a negedge. Raises the requesters in mask_in,
  // and serves each in round-robin order until all have been answered.
  task automatic serve(input logic [3:0] mask_in);
    logic [3:0]  m, em;
    logic [31:0] e;
    logic        bypass;
    int          w, t, g, p, lat_exp;
    m = mask_in;
    set_bus();
    req_valid = m;
    #1;
    while (m != 4'b0) begin
      w = rr_exp;
      while (!m[w]) w = (w + 1) % 4;
      t = 0;
      while (req_ready == 4'b0 && t < 40) begin
        @(negedge clk);
        #1;
        t++;
      end
      em    = 4'b0;
      em[w] = 1'b1;
      chk("grant", req_ready, em);
      g = cyc;
      p = dcnt;
      e = exp_div(ops[w], opa[w], opb[w]);
      bypass = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
      bypass = (opb[w] == 16'd0);
`endif
      if (!bypass) begin
        last_s = ops[w];
        last_a = opa[w];
        last_b = opb[w];
      end
      lat_exp = bypass ? 1 : (((p == 0) ? 17 : 17 - p) + 18);
      @(negedge clk);
      req_valid[w] = 1'b0;
      m[w] = 1'b0;
      chk("busy_after_grant", busy, !bypass);
      chk("div_operands", {15'd0, div_sign, div_dividend, div_divisor},
          {15'd0, last_s, last_a, last_b});
      t = 0;
      while (!resp_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("latency", cyc - g, lat_exp);
      chk("resp_id", resp_id, w);
      chk("resp_quotient", resp_quotient, e[31:16]);
      chk("resp_remainder", resp_remainder, e[15:0]);
      chk("resp_dz", resp_dz, opb[w] == 16'd0);
      rr_exp = (w + 1) % 4;
      #1;
    end
  endtask

  task automatic rand_op(input int i);
    int ma, mb;
    ops[i] = 1'($urandom_range(0, 1));
    if (!ops[i]) begin
      opa[i] = 16'($urandom);
      opb[i] = 16'($urandom_range(0, 300));
    end else begin
      ma = int'($urandom_range(300, 32767));
      mb = int'($urandom_range(1, 299));
      opa[i] = ($urandom_range(0, 1) == 1) ? 16'(-ma) : 16'(ma);
      opb[i] = ($urandom_range(0, 1) == 1) ? 16'(-mb) : 16'(mb);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int t, g, ghost;
    rst = 1'b1;
    req_valid = 4'b0;
    for (int i = 0; i < 4; i++) begin
      opa[i] = 16'd0;
      opb[i] = 16'd0;
      ops[i] = 1'b0;
    end
    set_bus();
    model_reset();
    repeat (3) @(negedge clk);
    zero_chk("por");
    rst = 1'b0;

    // Unsigned 1000/7 from requester 0.
    opa[0] = 16'd1000; opb[0] = 16'd7; ops[0] = 1'b0;
    @(negedge clk);
    serve(4'b0001);
    chk("u1000_7_q", resp_quotient, 16'd142);
    chk("u1000_7_r", resp_remainder, 16'd6);

    // Signed -100/7 from requester 1.
    opa[1] = 16'hFF9C; opb[1] = 16'd7; ops[1] = 1'b1;
    @(negedge clk);
    serve(4'b0010);
    chk("s100_7_q", resp_quotient, 16'hFFF2);
    chk("s100_7_r", resp_remainder, 16'hFFFE);

    // Round-robin from reset: all four, then requesters 0 and 2.
    do_reset();
    for (int i = 0; i < 4; i++) rand_op(i);
    @(negedge clk);
    serve(4'b1111);
    for (int i = 0; i < 4; i++) rand_op(i);
    @(negedge clk);
    serve(4'b0101);

    // Unsigned divide by zero from requester 3.
    opa[3] = 16'h1234; opb[3] = 16'd0; ops[3] = 1'b0;
    @(negedge clk);
    serve(4'b1000);
    chk("dz_q", resp_quotient, 16'hFFFF);
    chk("dz_r", resp_remainder, 16'h1234);
    chk("dz_flag", resp_dz, 1);

    // Reset in RUN: operation abandoned, no response.
    opa[0] = 16'd9999; opb[0] = 16'd11; ops[0] = 1'b0;
    @(negedge clk);
    set_bus();
    req_valid = 4'b0001;
    #1;
    t = 0;
    while (req_ready == 4'b0 && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("midop_grant", req_ready, 4'b0001);
    g = cyc;
    @(negedge clk);
    req_valid = 4'b0;
    t = 0;
    while (cyc < g + 18 && t < 40) begin
      @(negedge clk);
      t++;
    end
    rst = 1'b1;
    @(negedge clk);
    zero_chk("midop");
    rst = 1'b0;
    model_reset();
    ghost = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) ghost++;
    end
    chk("midop_no_resp", ghost, 0);
    opa[0] = 16'd500; opb[0] = 16'd3; ops[0] = 1'b0;
    serve(4'b0001);
    chk("u500_3_q", resp_quotient, 16'd166);
    chk("u500_3_r", resp_remainder, 16'd2);

    // Start 50000/123 at each of the 17 divider phases.
    for (int ph = 0; ph < 17; ph++) begin
      opa[0] = 16'd50000; opb[0] = 16'd123; ops[0] = 1'b0;
      @(negedge clk);
      t = 0;
      while (dcnt != ph && t < 40) begin
        @(negedge clk);
        t++;
      end
      serve(4'b0001);
      chk("sweep_q", resp_quotient, 16'd406);
      chk("sweep_r", resp_remainder, 16'd62);
    end

    // Random operand mixes and request masks.
    repeat (20) begin
      for (int i = 0; i < 4; i++) rand_op(i);
      @(negedge clk);
      serve(4'($urandom_range(1, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
